// File: rtl/memory_swap_master.sv
// memory_swap_master
//   Swap initiator for a plain dual-port RAM. The RAM has one synchronous read
//   port with a one-cycle latency and one write port. A request carries two
//   addresses over a valid/ready handshake. The block reads both locations,
//   writes each value back to the other location, and then pulses done.
//
// Ports
//   clk, reset            : single clock; synchronous active-high reset
//   req_valid/req_ready   : request handshake; ready only while idle
//   address_A/address_B   : swap addresses, latched on the accepting edge
//   busy                  : high in every state except IDLE
//   done                  : one-cycle completion pulse
//   swap_count            : saturating count of completed swaps
//   address_r, data_r     : RAM read port (data_r valid one cycle after address_r)
//   we, address_w, data_w : RAM write port
//
// Every output comes straight from a flop. Each output flop is loaded from the
// next-state decode, so its value is valid during the state it belongs to.
module memory_swap_master #(
  parameter int unsigned N     = 7,
  parameter int unsigned BITS  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     address_A,
  input  logic [N-1:0]     address_B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swap_count,
  output logic [N-1:0]     address_r,
  input  logic [BITS-1:0]  data_r,
  output logic             we,
  output logic [N-1:0]     address_w,
  output logic [BITS-1:0]  data_w
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    WR_A  = 3'd4,
    WR_B  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     addr_a_q, addr_a_d;
  logic [N-1:0]     addr_b_q, addr_b_d;
  logic [BITS-1:0]  tmp_a_q, tmp_a_d;
  logic [BITS-1:0]  tmp_b_q, tmp_b_d;
  logic [N-1:0]     address_r_q, address_r_d;
  logic [N-1:0]     address_w_q, address_w_d;
  logic [BITS-1:0]  data_w_q, data_w_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Saturating increment: the count sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state and next-output decode for the swap sequencer.
  always_comb begin
    state_d     = state_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    tmp_a_d     = tmp_a_q;
    tmp_b_d     = tmp_b_q;
    address_r_d = address_r_q;
    address_w_d = address_w_q;
    data_w_d    = data_w_q;
    count_d     = count_q;
    we_d        = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_a_d = address_A;
          addr_b_d = address_B;
          if (address_A != address_B) begin
            // The first read address must be on the RAM port during RD_A.
            state_d     = RD_A;
            address_r_d = address_A;
          end else begin
            // A self-swap is a no-op, so complete at once without RAM traffic.
            state_d = IDLE;
            done_d  = 1'b1;
            count_d = sat_inc(count_q);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        state_d     = RD_B;
        address_r_d = addr_b_q;
      end
      RD_B: begin
        // data_r now holds mem[addr_a] from the read issued in RD_A.
        tmp_a_d = data_r;
        state_d = CAP_B;
      end
      CAP_B: begin
        // data_r now holds mem[addr_b]; it is written straight to addr_a next.
        tmp_b_d     = data_r;
        state_d     = WR_A;
        we_d        = 1'b1;
        address_w_d = addr_a_q;
        data_w_d    = data_r;
      end
      WR_A: begin
        state_d     = WR_B;
        we_d        = 1'b1;
        address_w_d = addr_b_q;
        data_w_d    = tmp_a_q;
      end
      WR_B: begin
        state_d = IDLE;
        done_d  = 1'b1;
        count_d = sat_inc(count_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_a_q    <= {N{1'b0}};
      addr_b_q    <= {N{1'b0}};
      tmp_a_q     <= {BITS{1'b0}};
      tmp_b_q     <= {BITS{1'b0}};
      address_r_q <= {N{1'b0}};
      address_w_q <= {N{1'b0}};
      data_w_q    <= {BITS{1'b0}};
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      tmp_a_q     <= tmp_a_d;
      tmp_b_q     <= tmp_b_d;
      address_r_q <= address_r_d;
      address_w_q <= address_w_d;
      data_w_q    <= data_w_d;
      we_q        <= we_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = count_q;
  assign address_r  = address_r_q;
  assign we         = we_q;
  assign address_w  = address_w_q;
  assign data_w     = data_w_q;

endmodule

// File: tb/tb_memory_swap_master.sv
// Directed bench for memory_swap_master. A behavioural RAM with a one-cycle
// read latency sits on the main instance. A second instance is built with a
// 2-bit counter and is used only to check that the counter saturates.
module tb_memory_swap_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  address_A;
  logic [6:0]  address_B;
  logic        busy;
  logic        done;
  logic [15:0] swap_count;
  logic [6:0]  address_r;
  logic [7:0]  data_r;
  logic        we;
  logic [6:0]  address_w;
  logic [7:0]  data_w;

  // Signals of the saturation instance (CNT_W = 2).
  logic        s_valid;
  logic        s_ready;
  logic [6:0]  s_addr;
  logic        s_busy;
  logic        s_done;
  logic [1:0]  s_count;
  logic [6:0]  s_address_r;
  logic        s_we;
  logic [6:0]  s_address_w;
  logic [7:0]  s_data_w;

  // The bench preloads the RAM through this port.
  logic        pl_we;
  logic [6:0]  pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  mem [0:127];

  int n_checks;
  int n_fail;

  memory_swap_master #(.N(7), .BITS(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address_A(address_A), .address_B(address_B), .busy(busy), .done(done),
    .swap_count(swap_count), .address_r(address_r), .data_r(data_r),
    .we(we), .address_w(address_w), .data_w(data_w)
  );

  memory_swap_master #(.N(7), .BITS(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .req_valid(s_valid), .req_ready(s_ready),
    .address_A(s_addr), .address_B(s_addr), .busy(s_busy), .done(s_done),
    .swap_count(s_count), .address_r(s_address_r), .data_r(8'h00),
    .we(s_we), .address_w(s_address_w), .data_w(s_data_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read, and the DUT write has priority over preload.
  always @(posedge clk) begin
    if (we) begin
      mem[address_w] <= data_w;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
    data_r <= mem[address_r];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the bench drives and samples 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_we   = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    address_A = 7'd0;
    address_B = 7'd0;
    s_valid   = 1'b0;
    s_addr    = 7'd9;
    pl_we     = 1'b0;
    pl_addr   = 7'd0;
    pl_data   = 8'd0;
    #1;

    // Reset
    step();
    step();
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_count", 32'(swap_count), 32'd0);
    check_eq("rst_addr_w", 32'(address_w), 32'd0);
    reset = 1'b0;

    // Basic swap of (1, 2)
    preload(7'd1, 8'h11);
    preload(7'd2, 8'h22);
    req_valid = 1'b1;
    address_A = 7'd1;
    address_B = 7'd2;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) begin
        req_valid = 1'b0;
        address_A = 7'd77;
        address_B = 7'd78;
      end
      check_eq($sformatf("basic_we_c%0d", i), 32'(we), 32'((i == 4) || (i == 5)));
      check_eq($sformatf("basic_done_c%0d", i), 32'(done), 32'(i == 6));
      check_eq($sformatf("basic_busy_c%0d", i), 32'(busy), 32'(i != 6));
      if (i == 4) begin
        check_eq("basic_aw_a", 32'(address_w), 32'd1);
        check_eq("basic_dw_a", 32'(data_w), 32'h22);
      end
      if (i == 5) begin
        check_eq("basic_aw_b", 32'(address_w), 32'd2);
        check_eq("basic_dw_b", 32'(data_w), 32'h11);
      end
    end
    check_eq("basic_count", 32'(swap_count), 32'd1);
    check_eq("basic_mem1", 32'(mem[1]), 32'h22);
    check_eq("basic_mem2", 32'(mem[2]), 32'h11);
    step();
    check_eq("basic_done_low", 32'(done), 32'd0);

    // Equal addresses (5, 5)
    preload(7'd5, 8'h55);
    req_valid = 1'b1;
    address_A = 7'd5;
    address_B = 7'd5;
    step();
    req_valid = 1'b0;
    check_eq("eq_done", 32'(done), 32'd1);
    check_eq("eq_we", 32'(we), 32'd0);
    check_eq("eq_busy", 32'(busy), 32'd0);
    check_eq("eq_count", 32'(swap_count), 32'd2);
    step();
    check_eq("eq_done_low", 32'(done), 32'd0);
    check_eq("eq_we_low", 32'(we), 32'd0);
    check_eq("eq_mem5", 32'(mem[5]), 32'h55);

    // Back-to-back: (3, 4) then (0, 127) with req_valid held high
    preload(7'd3, 8'h33);
    preload(7'd4, 8'h44);
    preload(7'd0, 8'h0A);
    preload(7'd127, 8'h7F);
    req_valid = 1'b1;
    address_A = 7'd3;
    address_B = 7'd4;
    step();
    address_A = 7'd0;
    address_B = 7'd127;
    for (int i = 1; i <= 12; i++) begin
      if (i == 7) begin
        req_valid = 1'b0;
      end
      check_eq($sformatf("b2b_done_c%0d", i), 32'(done), 32'((i == 6) || (i == 12)));
      check_eq($sformatf("b2b_ready_c%0d", i), 32'(req_ready), 32'((i == 6) || (i == 12)));
      if (i == 6) begin
        check_eq("b2b_count1", 32'(swap_count), 32'd3);
      end
      if (i == 10) begin
        check_eq("b2b_aw_edge", 32'(address_w), 32'd0);
        check_eq("b2b_dw_edge", 32'(data_w), 32'h7F);
      end
      step();
    end
    check_eq("b2b_count2", 32'(swap_count), 32'd4);
    check_eq("b2b_mem3", 32'(mem[3]), 32'h44);
    check_eq("b2b_mem4", 32'(mem[4]), 32'h33);
    check_eq("b2b_mem0", 32'(mem[0]), 32'h7F);
    check_eq("b2b_mem127", 32'(mem[127]), 32'h0A);

    // Reset asserted during WR_A of swap (10, 11)
    preload(7'd10, 8'hAA);
    preload(7'd11, 8'hBB);
    req_valid = 1'b1;
    address_A = 7'd10;
    address_B = 7'd11;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    check_eq("rmid_we_wra", 32'(we), 32'd1);
    check_eq("rmid_aw_wra", 32'(address_w), 32'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rmid_we_after", 32'(we), 32'd0);
    check_eq("rmid_busy_after", 32'(busy), 32'd0);
    check_eq("rmid_count", 32'(swap_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rmid_done_c%0d", i), 32'(done), 32'd0);
      check_eq($sformatf("rmid_we_c%0d", i), 32'(we), 32'd0);
      step();
    end
    check_eq("rmid_mem10", 32'(mem[10]), 32'hBB);
    check_eq("rmid_mem11", 32'(mem[11]), 32'hBB);

    // Counter saturation on the CNT_W = 2 instance
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      check_eq($sformatf("sat_done_%0d", i), 32'(s_done), 32'd1);
      check_eq($sformatf("sat_count_%0d", i), 32'(s_count), (i < 3) ? 32'(i) : 32'd3);
      check_eq($sformatf("sat_we_%0d", i), 32'(s_we), 32'd0);
      step();
    end
    check_eq("sat_ready", 32'(s_ready), 32'd1);
    check_eq("sat_busy", 32'(s_busy), 32'd0);
    check_eq("sat_addr_r", 32'(s_address_r), 32'd0);
    check_eq("sat_addr_w", 32'(s_address_w), 32'd0);
    check_eq("sat_data_w", 32'(s_data_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
